nonce_report_tx: RTL and testbench
==================================

Name: nonce_report_tx

Overview:
Transmit-side packetiser for golden nonces found by the hashing core. It sits in the comm_clk domain, alongside the work-receive path of uart_comm. It queues nonce reports in a small FIFO and serialises each one as a framed byte packet over a byte-level valid/ready interface to the UART serialiser. The work-receive path's new_work flushes any stale queued reports.

Parameters:
FIFO_DEPTH_LOG2, 2, log2 of the nonce queue depth (default 4 entries).
SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
comm_clk  input  1  clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
golden_nonce  input  32  nonce value; sampled when new_golden_nonce=1.
new_golden_nonce  input  1  single-cycle push strobe, already synchronised into comm_clk.
flush  input  1  single-cycle pulse (driven from new_work); discards queued nonces.
tx_data  output  8  byte to transmit.
tx_valid  output  1  tx_data is valid.
tx_ready  input  1  serialiser accepts the byte this cycle.
busy  output  1  a packet is in flight (FSM not IDLE).
pending_count  output  FIFO_DEPTH_LOG2+1  queued nonces, excluding the one in flight.
drop_count  output  8  nonces dropped because the FIFO was full; saturates at 255.

Behaviour:
- Reset: synchronous, active-high, takes priority over all inputs.
  - All outputs go to 0.
  - FIFO is emptied; FSM goes to IDLE.
  - Reset mid-packet aborts the packet immediately; tx_valid=0 on the next cycle.
- Byte handshake:
  - A byte transfers on a cycle with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
- Packet format:
  - SYNC_BYTE, then nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24] (little-endian).
  - With CHECKSUM_EN, a trailing checksum byte follows (see Optional Feature).
- FSM states: IDLE, SEND_SYNC, SEND_DATA (2-bit byte index 0..3), SEND_CSUM.
  - IDLE: if the FIFO is non-empty, pop the head into a 32-bit shift register, assert tx_valid with tx_data=SYNC_BYTE, go to SEND_SYNC.
  - SEND_SYNC: on transfer, present nonce[7:0] and go to SEND_DATA with index 0.
  - SEND_DATA: on transfer, increment the index and present the next byte.
  - SEND_DATA at index 3: on transfer, go to SEND_CSUM with CHECKSUM_EN; otherwise deassert tx_valid and go to IDLE.
  - SEND_CSUM: on transfer, deassert tx_valid and go to IDLE.
- Latency and spacing:
  - A push at cycle N into an empty FIFO while IDLE gives tx_valid=1 at cycle N+2.
  - Back-to-back packets have exactly one cycle with tx_valid=0 between them (the IDLE cycle).
- FIFO push:
  - new_golden_nonce=1 and FIFO not full: the nonce is written.
  - FIFO full: the nonce is dropped and drop_count increments, saturating at 255.
  - Pop and push in the same cycle with the FIFO full: the push is accepted and not counted as a drop.
- Flush:
  - Empties the FIFO on the next edge; pending_count becomes 0.
  - A packet already in flight completes unaltered.
  - A push in the same cycle as flush is discarded (stale work) and is not counted in drop_count.
  - A pop in the same cycle as flush still takes the head.
  - drop_count is not cleared by flush.
- pending_count and busy are registered and update on the edge after the causing event.
- FIFO pointers are FIFO_DEPTH_LOG2+1 bits and wrap modulo 2^(FIFO_DEPTH_LOG2+1); full = MSBs differ and LSBs equal.

Optional Feature:
CHECKSUM_EN.
- Defined: packet is 6 bytes. The final byte is the XOR of the four nonce bytes, excluding SYNC_BYTE.
- Not defined: packet is 5 bytes, SEND_CSUM is unreachable, and no checksum logic is synthesised.

Test Plan:
- Reset, then a single push of golden_nonce=32'h12345678 with tx_ready=1 constantly -> bytes A5,78,56,34,12 (with CHECKSUM_EN, plus 08); tx_valid rises 2 cycles after the push; busy=0 after the last byte.
- Same packet with tx_ready toggling 1/0 every cycle -> identical byte sequence; tx_data stable while tx_ready=0; no byte lost or duplicated.
- Six pushes on consecutive cycles with tx_ready=0 -> 1 nonce in flight, pending_count=4, drop_count=1; releasing tx_ready yields 5 packets in push order.
- Three nonces queued, then flush pulsed mid-way through the first packet -> the first packet completes; pending_count=0; no further packets; a push in the flush cycle is not sent and drop_count is unchanged.
- 300 pushes with tx_ready=0 -> drop_count saturates at 255 and does not wrap.
- Reset asserted during byte 2 of a packet -> tx_valid=0 next cycle; FIFO empty; a later push of 32'hDEADBEEF yields A5,EF,BE,AD,DE.

Source files
------------

// File: rtl/nonce_report_tx.sv
// Golden-nonce report packetiser: queues nonces and sends each as SYNC + 4 LE bytes.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module nonce_report_tx #(
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                     comm_clk,
  input  logic                     reset,
  input  logic [31:0]              golden_nonce,
  input  logic                     new_golden_nonce,
  input  logic                     flush,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] pending_count,
  output logic [7:0]               drop_count
);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_CSUM} state_t;

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [AW:0] r_pending;
  logic [7:0]  r_drop;
  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_shift;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
`ifdef CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_empty, w_full, w_pop, w_push, w_drop, w_xfer;
  logic [31:0] w_head;
  logic [AW:0] w_wptr_nxt, w_rptr_nxt;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_push  = new_golden_nonce && !flush && (!w_full || w_pop);
  assign w_drop  = new_golden_nonce && !flush && w_full && !w_pop;
  assign w_xfer  = r_tx_valid && tx_ready;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
  assign w_rptr_nxt = flush ? r_wptr : (r_rptr + (AW+1)'(w_pop));

  always_ff @(posedge comm_clk) begin
    if (!reset && w_push) r_mem[r_wptr[AW-1:0]] <= golden_nonce;
  end

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pending <= '0;
      r_drop    <= '0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_pending <= w_wptr_nxt - w_rptr_nxt;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_shift    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_shift    <= w_head;
          r_tx_data  <= SYNC_BYTE;
          r_tx_valid <= 1'b1;
          r_state    <= ST_SYNC;
`ifdef CHECKSUM_EN
          r_csum     <= w_head[7:0] ^ w_head[15:8] ^ w_head[23:16] ^ w_head[31:24];
`endif
        end
        ST_SYNC: if (w_xfer) begin
          r_tx_data <= r_shift[7:0];
          r_shift   <= {8'h00, r_shift[31:8]};
          r_idx     <= '0;
          r_state   <= ST_DATA;
        end
        ST_DATA: if (w_xfer) begin
          if (r_idx == 2'd3) begin
`ifdef CHECKSUM_EN
            r_tx_data  <= r_csum;
            r_state    <= ST_CSUM;
`else
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
`endif
          end else begin
            r_tx_data <= r_shift[7:0];
            r_shift   <= {8'h00, r_shift[31:8]};
            r_idx     <= r_idx + 2'd1;
          end
        end
        default: if (w_xfer) begin
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_valid      = r_tx_valid;
  assign busy          = (r_state != ST_IDLE);
  assign pending_count = r_pending;
  assign drop_count    = r_drop;
endmodule

// File: tb/tb_nonce_report_tx.sv
// Scoreboarded random bench for nonce_report_tx against a queue-based packet model.
module tb_nonce_report_tx;
  localparam int DEPTH = 4;

  logic        comm_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] golden_nonce = '0;
  logic        new_golden_nonce = 1'b0;
  logic        flush = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [2:0]  pending_count;
  logic [7:0]  drop_count;

  always #5 comm_clk = ~comm_clk;

  nonce_report_tx #(.FIFO_DEPTH_LOG2(2), .SYNC_BYTE(8'hA5)) dut (
    .comm_clk(comm_clk), .reset(reset), .golden_nonce(golden_nonce),
    .new_golden_nonce(new_golden_nonce), .flush(flush), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .pending_count(pending_count), .drop_count(drop_count)
  );

  int          errs = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_pkt[$];
  logic [31:0] m_fifo[$];
  int          m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mk_pkt(input logic [31:0] n);
    m_pkt.delete();
    m_pkt.push_back(8'hA5);
    for (int b = 0; b < 4; b++) m_pkt.push_back(8'((n >> (8*b)) & 32'hFF));
`ifdef CHECKSUM_EN
    m_pkt.push_back(n[7:0] ^ n[15:8] ^ n[23:16] ^ n[31:24]);
`endif
  endtask

  // Drive one cycle, advance the model across the same edge, then compare state.
  task automatic step(input logic rst, input logic push, input logic [31:0] n,
                      input logic fl, input logic rdy);
    bit idle, was_full, pop;
    reset = rst; new_golden_nonce = push; golden_nonce = n; flush = fl; tx_ready = rdy;
    if (rst) begin
      m_fifo.delete(); m_pkt.delete(); m_drops = 0;
    end else begin
      idle = (m_pkt.size() == 0);
      was_full = (m_fifo.size() == DEPTH);
      pop = 1'b0;
      if (!idle && rdy) exp_q.push_back(m_pkt.pop_front());
      else if (idle && m_fifo.size() > 0) begin
        mk_pkt(m_fifo.pop_front());
        pop = 1'b1;
      end
      if (fl) m_fifo.delete();
      else if (push) begin
        if (was_full && !pop) begin
          if (m_drops < 255) m_drops++;
        end else m_fifo.push_back(n);
      end
    end
    @(posedge comm_clk); #1;
    chk("tx_valid", tx_valid, m_pkt.size() > 0);
    chk("busy", busy, m_pkt.size() > 0);
    chk("pending_count", pending_count, m_fifo.size());
    chk("drop_count", drop_count, m_drops);
    if (m_pkt.size() > 0) chk("tx_data", tx_data, m_pkt[0]);
  endtask

  task automatic idle_cycles(input int k, input logic rdy);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  always @(negedge comm_clk) begin : monitor
    logic [7:0] e;
    if (!reset && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL byte_stream: unexpected byte %0h with no expected byte", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errs++;
          $display("FAIL byte_stream: got %0h expected %0h at %0t", tx_data, e, $time);
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset tx_data", tx_data, 8'h00);

    // Single packet, ready held high.
    step(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("latency tx_valid", tx_valid, 1'b1);
    idle_cycles(8, 1'b1);

    // Same packet with ready toggling.
    step(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 1'b0, logic'(i % 2));

    // Six back-to-back pushes with ready low.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    chk("six pending", pending_count, 3'd4);
    chk("six drop", drop_count, 8'd1);
    idle_cycles(40, 1'b1);

    // Flush mid-packet with a coincident push.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    chk("flush pending", pending_count, 3'd0);
    chk("flush drop", drop_count, 8'd1);
    idle_cycles(20, 1'b1);

    // Drop counter saturation.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    chk("drop saturate", drop_count, 8'd255);

    // Reset mid-packet, then a fresh packet.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b1);
    idle_cycles(3, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("abort tx_valid", tx_valid, 1'b0);
    chk("abort pending", pending_count, 3'd0);
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    idle_cycles(10, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step(logic'($urandom % 300 == 0), logic'($urandom % 3 == 0), $urandom,
           logic'($urandom % 40 == 0), logic'($urandom % 4 != 0));
    idle_cycles(60, 1'b1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
